// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and flag layout for the 16-bit CPU
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SLL = 4'h6;
   localparam logic [3:0] OP_SRL = 4'h7;
   localparam logic [3:0] OP_SRA = 4'h8;
   localparam logic [3:0] OP_MUL = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_MOV = 4'hB;
   localparam logic [3:0] OP_LDI = 4'hC;
   // Opcodes from here up to F are undefined
   localparam logic [3:0] OP_ILL = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_EXEC = 2'd2
   } state_t;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] res,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (res == '0);
      f[FLAG_N] = res[DATA_W-1];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 16x16 shift-add multiplier, one partial product per cycle
module seq_multiplier
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] mcand;
   logic [DATA_W-1:0]   mplier;
   logic [3:0]          step;
   logic                running;
   logic [2*DATA_W-1:0] acc_nx;

   // The product is presented as the value after the step in progress, so it is
   // complete in the same cycle that done pulses on the sixteenth step.
   assign acc_nx  = mplier[0] ? acc + mcand : acc;
   assign done    = running && (step == 4'd15);
   assign product = acc_nx;

   // Load operands on start, then add/shift once per cycle for 16 cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         step    <= '0;
         running <= 1'b0;
      end else if (start) begin
         acc     <= '0;
         mcand   <= {{DATA_W{1'b0}}, a};
         mplier  <= b;
         step    <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc     <= acc_nx;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         step    <= step + 4'd1;
         if (step == 4'd15)
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/writeback stage with inline ALU, forwarding and sequential multiply
module exec_unit
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_op,
   input  logic [3:0]   in_rd,
   input  logic [3:0]   in_rs1,
   input  logic [3:0]   in_rs2,
   input  logic [7:0]   in_imm,
   output logic [3:0]   reg_read_addr_1,
   output logic [3:0]   reg_read_addr_2,
   input  logic [15:0]  reg_read_data_1,
   input  logic [15:0]  reg_read_data_2,
   output logic         reg_write_en,
   output logic [3:0]   reg_write_dest,
   output logic [15:0]  reg_write_data,
   output logic [3:0]   flags,
   output logic         illegal,
   output logic         busy
);

   state_t        state, state_nx;
   logic          accept;
   logic          mul_start;
   logic          mul_done;
   logic [31:0]   product;
   logic [3:0]    mul_rd;
   logic [15:0]   op_a, op_b;
   logic [15:0]   alu_res;
   logic          alu_c, alu_v, alu_wr;
   logic [3:0]    alu_flags;
   logic [16:0]   sum;
   logic [31:0]   shw;

   assign reg_read_addr_1 = in_rs1;
   assign reg_read_addr_2 = in_rs2;
   assign accept          = in_valid && in_ready;
   assign mul_start       = accept && (in_op == OP_MUL);

   seq_multiplier u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (product)
   );

   // Forward the result currently being written back; r0 is never forwarded
   always_comb begin
      op_a = reg_read_data_1;
      op_b = reg_read_data_2;
      if (reg_write_en && reg_write_dest != 4'd0 && reg_write_dest == in_rs1)
         op_a = reg_write_data;
      if (reg_write_en && reg_write_dest != 4'd0 && reg_write_dest == in_rs2)
         op_b = reg_write_data;
   end

   // Single-cycle ALU evaluated on the accept cycle; result registers at the accept edge
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b1;
      sum     = '0;
      shw     = '0;
      case (in_op)
         OP_ADD: begin
            sum     = {1'b0, op_a} + {1'b0, op_b};
            alu_res = sum[15:0];
            alu_c   = sum[16];
            alu_v   = (op_a[15] == op_b[15]) && (alu_res[15] != op_a[15]);
         end
         OP_SUB, OP_CMP: begin
            sum     = {1'b0, op_a} - {1'b0, op_b};
            alu_res = sum[15:0];
            alu_c   = sum[16];
            alu_v   = (op_a[15] != op_b[15]) && (alu_res[15] != op_a[15]);
            alu_wr  = (in_op != OP_CMP);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_NOT: alu_res = ~op_a;
         // Shifts run in a 32-bit window so the bit just past the result is the last one shifted out
         OP_SLL: begin
            shw     = {16'h0000, op_a} << op_b[3:0];
            alu_res = shw[15:0];
            alu_c   = shw[16];
         end
         OP_SRL: begin
            shw     = {op_a, 16'h0000} >> op_b[3:0];
            alu_res = shw[31:16];
            alu_c   = shw[15];
         end
         OP_SRA: begin
            shw     = $signed({op_a, 16'h0000}) >>> op_b[3:0];
            alu_res = shw[31:16];
            alu_c   = shw[15];
         end
         OP_MOV: alu_res = op_a;
         OP_LDI: alu_res = {8'h00, in_imm};
         default: alu_wr = 1'b0;
      endcase
      alu_flags = pack_flags(alu_res, alu_c, alu_v);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state)
         ST_IDLE, ST_WB: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nx = (in_op == OP_MUL) ? ST_EXEC : ST_WB;
            else
               state_nx = ST_IDLE;
         end
         ST_EXEC: begin
            busy = 1'b1;
            if (mul_done)
               state_nx = ST_WB;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Writeback and flag registers; write data/dest only move when a write actually happens
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
         flags          <= '0;
         illegal        <= 1'b0;
         mul_rd         <= '0;
      end else begin
         reg_write_en <= 1'b0;
         illegal      <= 1'b0;
         if (accept) begin
            if (in_op == OP_MUL) begin
               mul_rd <= in_rd;
            end else if (in_op >= OP_ILL) begin
               illegal <= 1'b1;
            end else begin
               flags <= alu_flags;
               if (alu_wr && in_rd != 4'd0) begin
                  reg_write_en   <= 1'b1;
                  reg_write_dest <= in_rd;
                  reg_write_data <= alu_res;
               end
            end
         end else if (mul_done) begin
            flags <= pack_flags(product[15:0], |product[31:16], 1'b0);
            if (mul_rd != 4'd0) begin
               reg_write_en   <= 1'b1;
               reg_write_dest <= mul_rd;
               reg_write_data <= product[15:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed table-driven bench for exec_unit
module tb_exec_unit;
   import cpu_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_op, in_rd, in_rs1, in_rs2;
   logic [7:0]   in_imm;
   logic [3:0]   reg_read_addr_1, reg_read_addr_2;
   logic [15:0]  reg_read_data_1, reg_read_data_2;
   logic         reg_write_en;
   logic [3:0]   reg_write_dest;
   logic [15:0]  reg_write_data;
   logic [3:0]   flags;
   logic         illegal;
   logic         busy;

   int tests = 0;
   int fails = 0;

   logic [15:0] rf [16];

   always #5 clk = ~clk;

   exec_unit dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_op           (in_op),
      .in_rd           (in_rd),
      .in_rs1          (in_rs1),
      .in_rs2          (in_rs2),
      .in_imm          (in_imm),
      .reg_read_addr_1 (reg_read_addr_1),
      .reg_read_addr_2 (reg_read_addr_2),
      .reg_read_data_1 (reg_read_data_1),
      .reg_read_data_2 (reg_read_data_2),
      .reg_write_en    (reg_write_en),
      .reg_write_dest  (reg_write_dest),
      .reg_write_data  (reg_write_data),
      .flags           (flags),
      .illegal         (illegal),
      .busy            (busy)
   );

   assign reg_read_data_1 = (reg_read_addr_1 == 4'd0) ? 16'h0000 : rf[reg_read_addr_1];
   assign reg_read_data_2 = (reg_read_addr_2 == 4'd0) ? 16'h0000 : rf[reg_read_addr_2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
         rf[1]  <= 16'h0F00;
         rf[2]  <= 16'h0050;
         rf[3]  <= 16'hFF0F;
         rf[5]  <= 16'h0040;
         rf[6]  <= 16'h0024;
         rf[7]  <= 16'h00FF;
         rf[12] <= 16'hFFFF;
         rf[13] <= 16'h0002;
      end else if (reg_write_en) begin
         rf[reg_write_dest] <= reg_write_data;
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [7:0]  imm;
      logic        en;
      logic [3:0]  dest;
      logic [15:0] data;
      logic [3:0]  flg;
      logic        ill;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [7:0] imm);
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_op    = 4'h0;
      in_rd    = 4'h0;
      in_rs1   = 4'h0;
      in_rs2   = 4'h0;
      in_imm   = 8'h00;
   endtask

   initial begin
      //          op      rd  rs1 rs2 imm    en  dest data     flags    ill
      vt[0]  = '{OP_ADD, 9,  1,  2,  8'h00, 1, 9,  16'h0F50, 4'b0000, 0};
      vt[1]  = '{OP_SUB, 11, 2,  1,  8'h00, 1, 11, 16'hF150, 4'b0110, 0};
      vt[2]  = '{OP_ADD, 10, 12, 13, 8'h00, 1, 10, 16'h0001, 4'b0010, 0};
      vt[3]  = '{OP_CMP, 0,  2,  2,  8'h00, 0, 10, 16'h0001, 4'b1000, 0};
      vt[4]  = '{OP_ADD, 0,  1,  2,  8'h00, 0, 10, 16'h0001, 4'b0000, 0};
      vt[5]  = '{OP_SRA, 9,  3,  13, 8'h00, 1, 9,  16'hFFC3, 4'b0110, 0};
      vt[6]  = '{OP_SLL, 9,  7,  13, 8'h00, 1, 9,  16'h03FC, 4'b0000, 0};
      vt[7]  = '{OP_LDI, 9,  0,  0,  8'hA5, 1, 9,  16'h00A5, 4'b0000, 0};
      vt[8]  = '{OP_MOV, 4,  3,  0,  8'h00, 1, 4,  16'hFF0F, 4'b0100, 0};
      vt[9]  = '{4'hF,   9,  1,  2,  8'h00, 0, 4,  16'hFF0F, 4'b0100, 1};
      vt[10] = '{OP_SRL, 9,  7,  13, 8'h00, 1, 9,  16'h003F, 4'b0010, 0};
      vt[11] = '{OP_XOR, 4,  1,  3,  8'h00, 1, 4,  16'hF00F, 4'b0100, 0};
      vt[12] = '{OP_AND, 4,  1,  3,  8'h00, 1, 4,  16'h0F00, 4'b0000, 0};
      vt[13] = '{OP_OR,  4,  2,  1,  8'h00, 1, 4,  16'h0F50, 4'b0000, 0};
      vt[14] = '{OP_NOT, 4,  12, 0,  8'h00, 1, 4,  16'h0000, 4'b1000, 0};
      vt[15] = '{OP_SRL, 4,  7,  0,  8'h00, 1, 4,  16'h00FF, 4'b0000, 0};

      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wen", reg_write_en, 0);
      chk("rst_dest", reg_write_dest, 0);
      chk("rst_data", reg_write_data, 0);
      chk("rst_flags", flags, 0);
      chk("rst_illegal", illegal, 0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
         chk($sformatf("v%0d_ready", i), in_ready, 1);
         @(negedge clk);
         idle_inputs();
         chk($sformatf("v%0d_wen", i), reg_write_en, vt[i].en);
         chk($sformatf("v%0d_dest", i), reg_write_dest, vt[i].dest);
         chk($sformatf("v%0d_data", i), reg_write_data, vt[i].data);
         chk($sformatf("v%0d_flags", i), flags, vt[i].flg);
         chk($sformatf("v%0d_illegal", i), illegal, vt[i].ill);
         @(negedge clk);
         chk($sformatf("v%0d_strobe_once", i), {reg_write_en, illegal}, 2'b00);
      end

      // Back-to-back dependent issue: rs1 then rs2 forwarded, r9 in the file is stale (003F)
      @(negedge clk);
      drive(OP_ADD, 9, 1, 2, 8'h00);
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
      chk("b2b_first", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd9, 16'h0F50});
      drive(OP_ADD, 10, 9, 2, 8'h00);
      @(negedge clk);
      chk("b2b_fwd_rs1", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd10, 16'h0FA0});
      drive(OP_ADD, 4, 2, 10, 8'h00);
      @(negedge clk);
      chk("b2b_fwd_rs2", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd4, 16'h0FF0});
      drive(OP_ADD, 0, 1, 2, 8'h00);
      @(negedge clk);
      drive(OP_ADD, 4, 0, 2, 8'h00);
      @(negedge clk);
      idle_inputs();
      chk("r0_no_fwd", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd4, 16'h0050});

      // Multiply 0040 * 0024
      @(negedge clk);
      drive(OP_MUL, 14, 5, 6, 8'h00);
      @(negedge clk);
      idle_inputs();
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("mul1_exec_c%0d", k), {busy, in_ready, reg_write_en}, 3'b100);
         @(negedge clk);
      end
      chk("mul1_write", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd14, 16'h0900});
      chk("mul1_flags", flags, 4'b0000);
      chk("mul1_ready", {busy, in_ready}, 2'b01);
      @(negedge clk);
      chk("mul1_strobe_once", reg_write_en, 0);

      // Multiply FFFF * FFFF: high half non-zero sets C
      drive(OP_MUL, 14, 12, 12, 8'h00);
      @(negedge clk);
      idle_inputs();
      for (int k = 1; k <= 16; k++) @(negedge clk);
      chk("mul2_write", {reg_write_en, reg_write_dest, reg_write_data}, {1'b1, 4'd14, 16'h0001});
      chk("mul2_flags", flags, 4'b0010);

      // Reset during the fifth EXEC cycle aborts the multiply
      @(negedge clk);
      drive(OP_MUL, 14, 5, 6, 8'h00);
      @(negedge clk);
      idle_inputs();
      for (int k = 1; k < 5; k++) @(negedge clk);
      chk("rstmul_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmul_async", {reg_write_en, busy, in_ready, illegal, flags}, {4'b0010, 4'b0000});
      @(negedge clk);
      rst = 1'b0;
      begin
         int writes;
         writes = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (reg_write_en) writes++;
         end
         chk("rstmul_no_write", writes, 0);
      end
      chk("rstmul_ready_after", {in_ready, busy}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
